// File: rtl/cp0_pkg.sv
// Shared encodings for the CP0 event arbiter: cause codes, event kinds,
// sequencer states, ring constants and the interrupt-level priority helper.
package cp0_pkg;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_0024;
  localparam int          STACK_DEPTH_DEF  = 4;

  localparam logic [2:0] RING_USER = 3'd0;
  localparam logic [2:0] RING_EXC  = 3'd4;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_UNDEF = 3'd1;
  localparam logic [2:0] CAUSE_OVF   = 3'd2;
  localparam logic [2:0] CAUSE_RANGE = 3'd4;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_EXC  = 2'd1,
    KIND_IRQ  = 2'd2,
    KIND_ERET = 2'd3
  } evt_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Highest pending line wins; line i maps to level i+1, 0 means nothing pending.
  function automatic logic [2:0] irq_level(input logic [2:0] pend);
    logic [2:0] lvl;
    lvl = 3'd0;
    if (pend[2])      lvl = 3'd3;
    else if (pend[1]) lvl = 3'd2;
    else if (pend[0]) lvl = 3'd1;
    return lvl;
  endfunction

  function automatic logic [2:0] level_mask(input logic [2:0] lvl);
    logic [2:0] mask;
    mask = 3'b000;
    case (lvl)
      3'd1:    mask = 3'b001;
      3'd2:    mask = 3'b010;
      3'd3:    mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ring_stack.sv
// Small LIFO holding the privilege rings to return to on ERET.
// An empty stack presents 0 (user ring) on top.
module ring_stack
  import cp0_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] top,
  output logic       empty,
  output logic       full
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [2:0]    mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] top_idx;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign top_idx = cnt_q - CW'(1);
  assign top     = empty ? 3'd0 : mem_q[top_idx[AW-1:0]];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !full)      cnt_d = cnt_q + CW'(1);
    else if (pop && !empty) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push && !full) mem_q[cnt_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cp0_event_arbiter.sv
// Picks one CP0 event per idle cycle (exception > interrupt > ERET), tracks the
// ring nesting, and drives the flush-then-redirect sequence plus a CP0 write strobe.
module cp0_event_arbiter
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter int          STACK_DEPTH  = STACK_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_en,
  input  logic        ie,
  input  logic [2:0]  exc_cause,
  input  logic [31:0] ex_pc,
  input  logic [31:0] id_pc,
  input  logic [2:0]  irq_in,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
  output logic        evt_valid,
  output logic [1:0]  evt_kind,
  output logic [2:0]  evt_cause,
  output logic [31:0] evt_epc,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [2:0]  ring,
  output logic [2:0]  irq_pending,
  output logic        double_fault,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [2:0]  ring_q, ring_d;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  irq_prev_q;
  logic        df_q, df_d;
  logic        evt_valid_q, evt_valid_d;
  evt_kind_e   kind_q, kind_d;
  logic [2:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;

  logic [2:0]  irq_edge;
  logic [2:0]  irq_lvl;
  logic [2:0]  clr_mask;
  logic        stk_push, stk_pop;
  logic [2:0]  stk_top;
  logic        stk_empty, stk_full;

  ring_stack #(.DEPTH(STACK_DEPTH)) u_ring_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (ring_q),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign irq_edge = irq_in & ~irq_prev_q;
  assign irq_lvl  = irq_level(pending_q);

  always_comb begin
    state_d     = state_q;
    ring_d      = ring_q;
    df_d        = df_q;
    evt_valid_d = 1'b0;
    kind_d      = kind_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    target_d    = target_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    clr_mask    = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (exc_cause != CAUSE_NONE && ie) begin
          evt_valid_d = 1'b1;
          kind_d      = KIND_EXC;
          cause_d     = exc_cause;
          epc_d       = ex_pc + 32'd4;
          target_d    = HANDLER_ADDR;
          state_d     = ST_FLUSH;
          // A nested exception cannot deepen the stack; it is flagged instead.
          if (ring_q == RING_EXC) begin
            df_d = 1'b1;
          end else begin
            stk_push = !stk_full;
            ring_d   = RING_EXC;
          end
        end else if (ie && irq_lvl > ring_q) begin
          evt_valid_d = 1'b1;
          kind_d      = KIND_IRQ;
          cause_d     = irq_lvl;
          epc_d       = id_pc;
          target_d    = HANDLER_ADDR;
          state_d     = ST_FLUSH;
          stk_push    = !stk_full;
          ring_d      = irq_lvl;
          clr_mask    = level_mask(irq_lvl);
        end else if (eret_req) begin
          evt_valid_d = 1'b1;
          kind_d      = KIND_ERET;
          cause_d     = CAUSE_NONE;
          epc_d       = 32'd0;
          target_d    = epc_in;
          state_d     = ST_FLUSH;
          stk_pop     = !stk_empty;
          ring_d      = stk_top;
        end
      end
      ST_FLUSH:    if (cpu_en) state_d = ST_REDIRECT;
      ST_REDIRECT: if (cpu_en) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // A fresh edge on a line being cleared keeps it pending.
    pending_d = (pending_q & ~clr_mask) | irq_edge;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ring_q      <= RING_USER;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      df_q        <= 1'b0;
      evt_valid_q <= 1'b0;
      kind_q      <= KIND_NONE;
      cause_q     <= '0;
      epc_q       <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      ring_q      <= ring_d;
      pending_q   <= pending_d;
      irq_prev_q  <= irq_in;
      df_q        <= df_d;
      evt_valid_q <= evt_valid_d;
      kind_q      <= kind_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      target_q    <= target_d;
    end
  end

  assign evt_valid      = evt_valid_q;
  assign evt_kind       = kind_q;
  assign evt_cause      = cause_q;
  assign evt_epc        = epc_q;
  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = target_q;
  assign ring           = ring_q;
  assign irq_pending    = pending_q;
  assign double_fault   = df_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cp0_event_arbiter.sv
// Scoreboard bench for cp0_event_arbiter: a behavioural model predicts events
// and ring/pending state; a negedge monitor compares the DUT against it.
module tb_cp0_event_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_en = 1'b0;
  logic        ie = 1'b0;
  logic [2:0]  exc_cause = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] id_pc = '0;
  logic [2:0]  irq_in = '0;
  logic        eret_req = 1'b0;
  logic [31:0] epc_in = '0;

  logic        evt_valid;
  logic [1:0]  evt_kind;
  logic [2:0]  evt_cause;
  logic [31:0] evt_epc;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  ring;
  logic [2:0]  irq_pending;
  logic        double_fault;
  logic        busy;

  cp0_event_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_en         (cpu_en),
    .ie             (ie),
    .exc_cause      (exc_cause),
    .ex_pc          (ex_pc),
    .id_pc          (id_pc),
    .irq_in         (irq_in),
    .eret_req       (eret_req),
    .epc_in         (epc_in),
    .evt_valid      (evt_valid),
    .evt_kind       (evt_kind),
    .evt_cause      (evt_cause),
    .evt_epc        (evt_epc),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ring           (ring),
    .irq_pending    (irq_pending),
    .double_fault   (double_fault),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          kind;
    int          cause;
    logic [31:0] epc;
    logic [31:0] tgt;
  } ev_t;

  ev_t      exp_q[$];
  int       m_stack[$];
  int       m_ring  = 0;
  bit [2:0] m_pend  = '0;
  bit [2:0] m_prev  = '0;
  bit       m_df    = 1'b0;
  int       m_phase = 0;   // 0 idle, 1 flushing, 2 redirecting
  bit       m_evt   = 1'b0;
  ev_t      m_cur;

  always @(posedge clk) begin : model
    bit [2:0] edges;
    bit [2:0] clr;
    int       lvl;
    bit       taken;
    ev_t      e;
    m_evt = 1'b0;
    if (!rst_n) begin
      m_stack.delete();
      exp_q.delete();
      m_ring  = 0;
      m_pend  = '0;
      m_prev  = '0;
      m_df    = 1'b0;
      m_phase = 0;
      m_cur   = '{0, 0, 32'd0, 32'd0};
    end else begin
      edges = irq_in & ~m_prev;
      clr   = '0;
      taken = 1'b0;
      lvl   = 0;
      for (int i = 0; i < 3; i++) if (m_pend[i]) lvl = i + 1;
      if (m_phase == 0) begin
        if (exc_cause != 0 && ie) begin
          e = '{1, int'(exc_cause), ex_pc + 32'd4, 32'h24};
          taken = 1'b1;
          if (m_ring == 4) m_df = 1'b1;
          else begin
            m_stack.push_back(m_ring);
            m_ring = 4;
          end
        end else if (ie && lvl > m_ring) begin
          e = '{2, lvl, id_pc, 32'h24};
          taken = 1'b1;
          m_stack.push_back(m_ring);
          m_ring = lvl;
          clr[lvl-1] = 1'b1;
        end else if (eret_req) begin
          e = '{3, 0, 32'd0, epc_in};
          taken = 1'b1;
          if (m_stack.size() > 0) m_ring = m_stack.pop_back();
          else m_ring = 0;
        end
        if (taken) begin
          m_phase = 1;
          m_evt   = 1'b1;
          m_cur   = e;
          exp_q.push_back(e);
        end
      end else if (cpu_en) begin
        m_phase = (m_phase == 1) ? 2 : 0;
      end
      m_pend = (m_pend & ~clr) | edges;
      m_prev = irq_in;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    ev_t e;
    check("ring", 32'(ring), 32'(m_ring));
    check("irq_pending", 32'(irq_pending), 32'(m_pend));
    check("double_fault", 32'(double_fault), 32'(m_df));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("flush", 32'(flush), 32'(m_phase == 1));
    check("redirect_valid", 32'(redirect_valid), 32'(m_phase == 2));
    check("evt_valid", 32'(evt_valid), 32'(m_evt));
    if (m_evt) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got event with empty queue, expected queued event");
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", 32'(evt_kind), 32'(e.kind));
        check("evt_cause", 32'(evt_cause), 32'(e.cause));
        check("evt_epc", evt_epc, e.epc);
        $display("event t=%0t kind=%0d cause=%0d epc=%h target=%h ring=%0d",
                 $time, e.kind, e.cause, e.epc, e.tgt, m_ring);
      end
    end
    if (m_phase != 0) begin
      check("evt_kind_hold", 32'(evt_kind), 32'(m_cur.kind));
      check("evt_epc_hold", evt_epc, m_cur.epc);
      check("redirect_pc", redirect_pc, m_cur.tgt);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tick(2);
    check("rst_ring", 32'(ring), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; ie = 1'b1; cpu_en = 1'b1;

    // Level-2 interrupt from user ring
    irq_in = 3'b010; id_pc = 32'h200;
    tick(5);
    check("s1_ring", 32'(ring), 32'd2);
    check("s1_pending", 32'(irq_pending), 32'd0);

    // Level 1 blocked in ring 2, then ERET returns to ring 0
    irq_in = 3'b011;
    tick(2);
    check("s2_pending", 32'(irq_pending), 32'b001);
    check("s2_ring_hold", 32'(ring), 32'd2);
    eret_req = 1'b1; epc_in = 32'h100;
    tick(1);
    eret_req = 1'b0;
    check("s2_eret_ring", 32'(ring), 32'd0);
    tick(1);
    check("s2_redirect_valid", 32'(redirect_valid), 32'd1);
    check("s2_redirect_pc", redirect_pc, 32'h100);
    tick(2);
    check("s2_lvl1_ring", 32'(ring), 32'd1);
    tick(3);
    eret_req = 1'b1; epc_in = 32'h180;
    tick(1);
    eret_req = 1'b0;
    tick(3);

    // Exception beats a new interrupt edge and an ERET in the same cycle
    irq_in = 3'b000;
    tick(1);
    exc_cause = 3'd2; ex_pc = 32'h40; irq_in = 3'b100; eret_req = 1'b1;
    tick(1);
    exc_cause = 3'd0; eret_req = 1'b0;
    check("s3_ring", 32'(ring), 32'd4);
    check("s3_kind", 32'(evt_kind), 32'd1);
    check("s3_epc", evt_epc, 32'h44);
    check("s3_pending", 32'(irq_pending), 32'b100);
    tick(3);

    // Double fault with EPC wrap-around, then a single ERET unwinds it
    exc_cause = 3'd1; ex_pc = 32'hFFFF_FFFC;
    tick(1);
    exc_cause = 3'd0;
    check("s4_double_fault", 32'(double_fault), 32'd1);
    check("s4_ring", 32'(ring), 32'd4);
    check("s4_epc_wrap", evt_epc, 32'd0);
    tick(1);
    check("s4_redirect_pc", redirect_pc, 32'h24);
    tick(1);
    eret_req = 1'b1; epc_in = 32'h300;
    tick(1);
    eret_req = 1'b0;
    check("s4_eret_ring", 32'(ring), 32'd0);
    tick(6);

    // Stalled sequence: flush stretches while cpu_en is low
    exc_cause = 3'd4; ex_pc = 32'h1000; cpu_en = 1'b0;
    tick(1);
    exc_cause = 3'd0;
    check("s5_evt_valid_first", 32'(evt_valid), 32'd1);
    check("s5_flush_0", 32'(flush), 32'd1);
    tick(1);
    check("s5_evt_valid_once", 32'(evt_valid), 32'd0);
    check("s5_flush_1", 32'(flush), 32'd1);
    tick(1);
    check("s5_flush_2", 32'(flush), 32'd1);
    tick(1);
    check("s5_flush_3", 32'(flush), 32'd1);
    check("s5_no_redirect", 32'(redirect_valid), 32'd0);
    cpu_en = 1'b1;
    tick(1);
    check("s5_redirect", 32'(redirect_valid), 32'd1);
    check("s5_flush_done", 32'(flush), 32'd0);
    tick(2);

    // Reset in the middle of a flush, then ERET with an empty stack
    exc_cause = 3'd1; ex_pc = 32'h2000;
    tick(1);
    exc_cause = 3'd0; rst_n = 1'b0; irq_in = 3'b000;
    tick(1);
    check("s6_evt_valid", 32'(evt_valid), 32'd0);
    check("s6_flush", 32'(flush), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_ring", 32'(ring), 32'd0);
    check("s6_pending", 32'(irq_pending), 32'd0);
    check("s6_df", 32'(double_fault), 32'd0);
    check("s6_redirect_pc", redirect_pc, 32'd0);
    check("s6_evt_epc", evt_epc, 32'd0);
    rst_n = 1'b1;
    eret_req = 1'b1; epc_in = 32'h500;
    tick(1);
    eret_req = 1'b0;
    check("s6_eret_empty_ring", 32'(ring), 32'd0);
    tick(1);
    check("s6_eret_redirect", redirect_pc, 32'h500);
    tick(2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      cpu_en   = ($urandom_range(0, 3) != 0);
      ie       = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 29))
        0:       exc_cause = 3'd1;
        1:       exc_cause = 3'd2;
        2:       exc_cause = 3'd4;
        default: exc_cause = 3'd0;
      endcase
      ex_pc    = $urandom;
      id_pc    = $urandom;
      if ($urandom_range(0, 3) == 0) irq_in = 3'($urandom_range(0, 7));
      eret_req = ($urandom_range(0, 4) == 0);
      epc_in   = $urandom;
      tick(1);
    end

    rst_n = 1'b1; cpu_en = 1'b1; exc_cause = 3'd0; eret_req = 1'b0; ie = 1'b0;
    tick(6);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_event_arbiter.md
# cp0_event_arbiter

Sequencer and arbiter for CP0 entry and exit. Each cycle it picks one event from three sources: EX-stage synchronous exceptions, external interrupt lines and ID-stage ERET. It maintains the privilege-ring nesting stack. It then drives a fixed flush-then-redirect sequence toward the pipeline, plus a one-cycle event strobe toward the CP0 register file, which records Cause and EPC from that strobe.

## Interface
- HANDLER_ADDR, 32'h0000_0024: exception/interrupt handler entry PC.
- STACK_DEPTH, 4: ring-stack entries; fixed by the ring scheme, not meant to change.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cpu_en  in  1  pipeline advance enable; 0 = stalled.
- ie  in  1  global enable (Status[15:8]==8'hff); gates exceptions and interrupts, not ERET.
- exc_cause  in  3  EX exception: 1 undefined, 2 overflow, 4 out-of-range, 0 none.
- ex_pc  in  32  PC of EX-stage instruction.
- id_pc  in  32  PC of ID-stage instruction.
- irq_in  in  3  interrupt lines; bit i = level i+1.
- eret_req  in  1  ERET decoded in ID.
- epc_in  in  32  current CP0 EPC (ERET target).
- evt_valid  out  1  one-cycle CP0 write strobe.
- evt_kind  out  2  0 none, 1 exception, 2 interrupt, 3 eret.
- evt_cause  out  3  cause code (exception) or level (interrupt).
- evt_epc  out  32  EPC value to store.
- flush  out  1  kill IF/ID/EX contents.
- redirect_valid  out  1  load redirect_pc into PC.
- redirect_pc  out  32  redirect target.
- ring  out  3  current ring: 0 user, 1-3 interrupt level, 4 exception.
- irq_pending  out  3  latched pending lines.
- double_fault  out  1  sticky: exception taken while ring==4.
- busy  out  1  state != IDLE.

## Operation
- Pending: irq_pending[i] is set on a 0->1 edge of irq_in[i] (registered previous value). It is cleared when level i+1 is accepted. If a clear and a new edge hit the same bit in the same cycle, the bit stays set.
- Interrupt level L = highest set pending bit + 1.
- Acceptance is evaluated only in IDLE. Priority: exception > interrupt > ERET.
  - Exception: exc_cause!=0 && ie. evt_epc = ex_pc+4 (mod 2^32). Target is HANDLER_ADDR. Pushes ring; ring becomes 4. If ring is already 4: no push, ring stays 4, double_fault set.
  - Interrupt: ie && L>ring. evt_epc = id_pc. Target is HANDLER_ADDR. Pushes ring; ring becomes L. Because rings strictly increase, at most 4 pushes can occur and the stack never overflows.
  - ERET: eret_req. Target is epc_in. Pops the stack into ring. If the stack is empty, ring becomes 0 and the stack is unchanged. evt_epc = 0.
- A losing ERET is dropped; it sits in ID and is flushed. An interrupt's EPC is that ERET's PC, so it re-executes.
- Any losing interrupt remains pending.
- FSM:
  - IDLE: on accept, register kind/cause/epc/target, assert evt_valid, go to FLUSH.
  - FLUSH: flush=1. Hold while cpu_en=0. On a cycle with cpu_en=1, go to REDIRECT.
  - REDIRECT: redirect_valid=1. Hold while cpu_en=0. On a cycle with cpu_en=1, go to IDLE.
- Exceptions and ERETs seen outside IDLE are ignored; they belong to flushed instructions. irq edges are still latched.

## Timing
- Inputs sampled at edge N. evt_valid, flush, the ring update and the stack update are all visible in cycle N+1.
- evt_valid is high exactly one cycle (the first FLUSH cycle) regardless of cpu_en.
- With cpu_en constantly 1: flush during N+1, redirect_valid during N+2, IDLE again and able to accept at edge N+3.
- redirect_pc and evt_* hold stable from N+1 until the return to IDLE.
- Reset (rst_n=0 at an edge), including mid-sequence: state IDLE, ring 0, stack empty, pending 0, edge history 0, double_fault 0, all outputs 0.

## Structure
- Shared package cp0_pkg: cause codes, evt_kind encodings, FSM state enum, RING_EXC=4, default HANDLER_ADDR.
- Sub-module ring_stack: STACK_DEPTH x 3-bit LIFO.
  - Inputs: push, pop, din.
  - Outputs: top, empty, full.
  - Pop when empty returns 0.
  - Push and pop are never asserted together.

## Test plan
- Reset, ie=1, irq_in=3'b010 edge, cpu_en=1 -> next cycle evt_valid, kind 2, cause 2, evt_epc=id_pc, flush. Following cycle redirect_valid, redirect_pc=0x24. ring=2, pending=0.
- While in ring 2, raise irq_in[0] (level 1) -> not accepted, pending=3'b001. Then ERET with epc_in=0x100 -> redirect 0x100, ring 0. Level 1 is then taken at the next IDLE cycle.
- Same cycle: exc_cause=2, ex_pc=0x40, irq edge level 3, eret_req=1 -> exception wins, evt_epc=0x44, ring 4. Level 3 stays pending.
- Exception while ring=4 -> double_fault=1, redirect 0x24, ring stays 4. A single ERET returns to the ring before the first exception.
- cpu_en=0 for 3 cycles after accept -> evt_valid 1 cycle, flush held 3+1 cycles, redirect follows only when cpu_en=1.
- rst_n=0 during FLUSH -> next cycle all outputs 0, busy=0. ERET with empty stack -> ring 0, redirect epc_in.
